// File: rtl/cfg_shiftreg_if.sv
// Bundle of the serial configuration pins and the decoded outputs of one
// cfg_shiftreg chain stage; clock and reset stay outside as plain ports.
interface cfg_shiftreg_if #(
  parameter int N      = 60,
  parameter int PARITY = 1
);
  localparam int FRAME = N + PARITY;
  localparam int CW    = $clog2(FRAME + 2);

  // Protocol: sdin is taken only on sclk edges where sen is high. latch is
  // acted on only at its rising edge, and that edge wins over a shift in the
  // same cycle. err_clr is level-sensitive and is applied on the next edge.
  logic          sen;
  logic          sdin;
  logic          latch;
  logic          err_clr;
  logic          sdout;
  logic [N-1:0]  cfg_out;
  logic          cfg_valid;
  logic          err_len;
  logic          err_par;
  logic [CW-1:0] bit_cnt;

  modport master (
    output sen, sdin, latch, err_clr,
    input  sdout, cfg_out, cfg_valid, err_len, err_par, bit_cnt
  );

  modport slave (
    input  sen, sdin, latch, err_clr,
    output sdout, cfg_out, cfg_valid, err_len, err_par, bit_cnt
  );
endinterface

// File: rtl/cfg_shiftreg.sv
// Serial configuration chain: shifts in a frame, checks its length and even
// parity on a latch rising edge, and only then updates the shadow register.
module cfg_shiftreg #(
  parameter int           N         = 60,
  parameter int           PARITY    = 1,
  parameter int           MSB_FIRST = 1,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input logic           sclk,
  input logic           rst_n,
  cfg_shiftreg_if.slave bus
);
  localparam int FRAME = N + PARITY;
  localparam int CW    = $clog2(FRAME + 2);
  localparam logic [CW-1:0] CNT_FRAME = CW'(FRAME);
  localparam logic [CW-1:0] CNT_SAT   = CW'(FRAME + 1);

  logic [FRAME-1:0] sr_q, sr_d;
  logic [N-1:0]     cfg_q, cfg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_len_q, err_len_d;
  logic             err_par_q, err_par_d;
  logic             latch_prev_q;

  logic [FRAME-1:0] sr_shifted;
  logic [N-1:0]     frame_data;
  logic             sdout_w;
  logic             latch_ev;
  logic             shift_en;
  logic             len_ok;
  logic             par_ok;
  logic             load;

  // Shift direction decides where the first bit ends up and which end of the
  // chain feeds the next stage; the parity bit sits at the entry end.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign sr_shifted = {sr_q[FRAME-2:0], bus.sdin};
      assign sdout_w    = sr_q[FRAME-1];
      assign frame_data = sr_q[FRAME-1:PARITY];
    end else begin : g_lsb_first
      assign sr_shifted = {bus.sdin, sr_q[FRAME-1:1]};
      assign sdout_w    = sr_q[0];
      assign frame_data = sr_q[N-1:0];
    end
  endgenerate

  always_comb begin
    latch_ev = bus.latch & ~latch_prev_q;
    shift_en = bus.sen & ~latch_ev;
    len_ok   = (cnt_q == CNT_FRAME);
    par_ok   = (PARITY == 0) || !(^sr_q);
    load     = latch_ev & len_ok & par_ok;
  end

  // A latch never clears sr so upstream data keeps flowing to sdout.
  always_comb begin
    sr_d = sr_q;
    if (shift_en) begin
      sr_d = sr_shifted;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (latch_ev) begin
      cnt_d = '0;
    end else if (shift_en && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    cfg_d   = cfg_q;
    valid_d = valid_q;
    if (load) begin
      cfg_d   = frame_data;
      valid_d = 1'b1;
    end
  end

  // Clear first, then set, so a same-cycle error report survives err_clr.
  always_comb begin
    err_len_d = err_len_q;
    err_par_d = err_par_q;
    if (bus.err_clr) begin
      err_len_d = 1'b0;
      err_par_d = 1'b0;
    end
    if (latch_ev && !len_ok) begin
      err_len_d = 1'b1;
    end
    if (latch_ev && len_ok && !par_ok) begin
      err_par_d = 1'b1;
    end
  end

  // latch_prev_q resets high so a latch pin tied high never fires.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q         <= '0;
      cfg_q        <= RESET_VAL;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      err_len_q    <= 1'b0;
      err_par_q    <= 1'b0;
      latch_prev_q <= 1'b1;
    end else begin
      sr_q         <= sr_d;
      cfg_q        <= cfg_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      err_len_q    <= err_len_d;
      err_par_q    <= err_par_d;
      latch_prev_q <= bus.latch;
    end
  end

  assign bus.sdout     = sdout_w;
  assign bus.cfg_out   = cfg_q;
  assign bus.cfg_valid = valid_q;
  assign bus.err_len   = err_len_q;
  assign bus.err_par   = err_par_q;
  assign bus.bit_cnt   = cnt_q;
endmodule

// File: tb/tb_cfg_shiftreg.sv
// Bench for cfg_shiftreg: an MSB-first and an LSB-first instance share one
// input stream and are compared against a frame-level model of the chain.
module tb_cfg_shiftreg;
  localparam int N     = 60;
  localparam int FRAME = N + 1;
  localparam int CW    = $clog2(FRAME + 2);
  localparam logic [N-1:0] RV   = 60'h5A50F0F1234ABCD;
  localparam logic [N-1:0] GOLD = 60'hEADBEEFFEEDFACE;

  // clock / reset
  logic sclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 sclk = ~sclk;

  logic sen = 1'b0, sdin = 1'b0, latch = 1'b0, err_clr = 1'b0;

  cfg_shiftreg_if #(.N(N), .PARITY(1)) if_m ();
  cfg_shiftreg_if #(.N(N), .PARITY(1)) if_l ();

  assign if_m.sen = sen;  assign if_m.sdin = sdin;
  assign if_m.latch = latch;  assign if_m.err_clr = err_clr;
  assign if_l.sen = sen;  assign if_l.sdin = sdin;
  assign if_l.latch = latch;  assign if_l.err_clr = err_clr;

  cfg_shiftreg #(.N(N), .PARITY(1), .MSB_FIRST(1), .RESET_VAL(RV)) u_msb (
    .sclk(sclk), .rst_n(rst_n), .bus(if_m.slave));
  cfg_shiftreg #(.N(N), .PARITY(1), .MSB_FIRST(0), .RESET_VAL(RV)) u_lsb (
    .sclk(sclk), .rst_n(rst_n), .bus(if_l.slave));

  int n_checks = 0;
  int n_errors = 0;

  // reference model: the last FRAME accepted bits, oldest first
  bit           m_win[$];
  int           m_cnt;
  bit           m_lprev;
  logic [N-1:0] m_cfg_m, m_cfg_l;
  bit           m_valid, m_errl, m_errp;

  function automatic logic [N-1:0] win_data(input bit msb_first);
    logic [N-1:0] d = '0;
    for (int i = 0; i < N; i++) begin
      if (msb_first) d[N-1-i] = m_win[i];
      else           d[i]     = m_win[i];
    end
    return d;
  endfunction

  function automatic int win_ones();
    int c = 0;
    foreach (m_win[i]) c += int'(m_win[i]);
    return c;
  endfunction

  task automatic model_reset();
    m_win.delete();
    repeat (FRAME) m_win.push_back(1'b0);
    m_cnt = 0; m_lprev = 1'b1;
    m_cfg_m = RV; m_cfg_l = RV;
    m_valid = 1'b0; m_errl = 1'b0; m_errp = 1'b0;
  endtask

  // driver: apply one cycle of inputs, advance the model across the edge
  task automatic tick(input bit s, input bit d, input bit l, input bit c);
    bit ev, len_ok, par_ok;
    sen = s; sdin = d; latch = l; err_clr = c;
    @(posedge sclk);
    ev     = l && !m_lprev;
    len_ok = (m_cnt == FRAME);
    par_ok = (win_ones() % 2) == 0;
    if (c) begin m_errl = 1'b0; m_errp = 1'b0; end
    if (ev) begin
      if (len_ok && par_ok) begin
        m_cfg_m = win_data(1'b1); m_cfg_l = win_data(1'b0); m_valid = 1'b1;
      end
      if (!len_ok) m_errl = 1'b1;
      else if (!par_ok) m_errp = 1'b1;
      m_cnt = 0;
    end else if (s) begin
      m_win.push_back(d);
      void'(m_win.pop_front());
      if (m_cnt < FRAME + 1) m_cnt++;
    end
    m_lprev = l;
    #1;
  endtask

  task automatic apply_reset(input bit latch_level);
    sen = 1'b0; sdin = 1'b0; err_clr = 1'b0; latch = latch_level;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge sclk);
    @(negedge sclk);
    rst_n = 1'b1;
    #1;
  endtask

  // shifts v[nb-1] first down to v[0]
  task automatic shift_vec(input logic [127:0] v, input int nb, input bit l);
    for (int k = nb - 1; k >= 0; k--) tick(1'b1, v[k], l, 1'b0);
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    n_checks++; if (if_m.cfg_out !== RV) begin n_errors++; $display("FAIL reset_cfg_out: got %h expected %h", if_m.cfg_out, RV); end
    n_checks++; if (if_l.cfg_out !== RV) begin n_errors++; $display("FAIL reset_cfg_out_lsb: got %h expected %h", if_l.cfg_out, RV); end
    n_checks++; if ({if_m.cfg_valid, if_m.err_len, if_m.err_par} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b expected 000", {if_m.cfg_valid, if_m.err_len, if_m.err_par}); end
    n_checks++; if (if_m.bit_cnt !== '0) begin n_errors++; $display("FAIL reset_bit_cnt: got %0d expected 0", if_m.bit_cnt); end
    n_checks++; if (if_m.sdout !== 1'b0) begin n_errors++; $display("FAIL reset_sdout: got %b expected 0", if_m.sdout); end
  endtask

  task automatic test_valid_frame();
    logic [127:0] v;
    logic [N-1:0] rev;
    apply_reset(1'b0);
    v = 128'({GOLD, 1'b1});
    shift_vec(v, FRAME, 1'b0);
    n_checks++; if (if_m.bit_cnt !== CW'(FRAME)) begin n_errors++; $display("FAIL valid_cnt_before: got %0d expected %0d", if_m.bit_cnt, FRAME); end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) rev[i] = GOLD[N-1-i];
    n_checks++; if (if_m.cfg_out !== GOLD) begin n_errors++; $display("FAIL valid_cfg_out: got %h expected %h", if_m.cfg_out, GOLD); end
    n_checks++; if (if_l.cfg_out !== rev) begin n_errors++; $display("FAIL valid_cfg_out_lsb: got %h expected %h", if_l.cfg_out, rev); end
    n_checks++; if ({if_m.cfg_valid, if_m.err_len, if_m.err_par} !== 3'b100) begin n_errors++; $display("FAIL valid_flags: got %b expected 100", {if_m.cfg_valid, if_m.err_len, if_m.err_par}); end
    n_checks++; if (if_m.bit_cnt !== '0) begin n_errors++; $display("FAIL valid_cnt_after: got %0d expected 0", if_m.bit_cnt); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_parity_error();
    logic [127:0] v;
    apply_reset(1'b0);
    v = 128'({GOLD, 1'b0});
    shift_vec(v, FRAME, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (if_m.cfg_out !== RV) begin n_errors++; $display("FAIL par_cfg_hold: got %h expected %h", if_m.cfg_out, RV); end
    n_checks++; if ({if_m.cfg_valid, if_m.err_len, if_m.err_par} !== 3'b001) begin n_errors++; $display("FAIL par_flags: got %b expected 001", {if_m.cfg_valid, if_m.err_len, if_m.err_par}); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({if_m.err_len, if_m.err_par} !== 2'b00) begin n_errors++; $display("FAIL par_err_clr: got %b expected 00", {if_m.err_len, if_m.err_par}); end
  endtask

  task automatic test_length_errors();
    logic [127:0] v;
    apply_reset(1'b0);
    v = 128'(GOLD);
    shift_vec(v, N, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if ({if_m.err_len, if_m.err_par} !== 2'b10) begin n_errors++; $display("FAIL short_flags: got %b expected 10", {if_m.err_len, if_m.err_par}); end
    n_checks++; if (if_m.cfg_out !== RV) begin n_errors++; $display("FAIL short_cfg_hold: got %h expected %h", if_m.cfg_out, RV); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    shift_vec(v, 70, 1'b0);
    n_checks++; if (if_m.bit_cnt !== CW'(62)) begin n_errors++; $display("FAIL long_saturate: got %0d expected 62", if_m.bit_cnt); end
    // err_clr in the same cycle as a failing latch: the error must stay set
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (if_m.err_len !== 1'b1) begin n_errors++; $display("FAIL long_err_len: got %b expected 1", if_m.err_len); end
    n_checks++; if (if_m.bit_cnt !== '0) begin n_errors++; $display("FAIL long_cnt_clear: got %0d expected 0", if_m.bit_cnt); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_tied_high();
    logic [127:0] v;
    logic [N-1:0] inv;
    apply_reset(1'b1);
    v = 128'({GOLD, 1'b1});
    shift_vec(v, FRAME, 1'b1);
    n_checks++; if ({if_m.cfg_valid, if_m.err_len, if_m.err_par} !== 3'b000 || if_m.cfg_out !== RV) begin n_errors++; $display("FAIL tied_no_update: got %h/%b expected %h/000", if_m.cfg_out, {if_m.cfg_valid, if_m.err_len, if_m.err_par}, RV); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (if_m.cfg_out !== GOLD || if_m.cfg_valid !== 1'b1) begin n_errors++; $display("FAIL tied_single_update: got %h/%b expected %h/1", if_m.cfg_out, if_m.cfg_valid, GOLD); end
    inv = ~GOLD;
    v = 128'({inv, ^inv});
    shift_vec(v, FRAME, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (if_m.cfg_out !== GOLD) begin n_errors++; $display("FAIL tied_held_high: got %h expected %h", if_m.cfg_out, GOLD); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_collision();
    logic [127:0] v;
    logic [N-1:0] d, rev;
    apply_reset(1'b0);
    v = 128'(GOLD);
    shift_vec(v, N, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++; if ({if_m.err_len, if_m.err_par} !== 2'b10) begin n_errors++; $display("FAIL coll_flags: got %b expected 10", {if_m.err_len, if_m.err_par}); end
    n_checks++; if (if_m.bit_cnt !== '0 || if_m.cfg_out !== RV) begin n_errors++; $display("FAIL coll_cnt_cfg: got %0d/%h expected 0/%h", if_m.bit_cnt, if_m.cfg_out, RV); end
    // sdout walks out the old chain contents; a shifted collision bit would skew it
    d = N'({$urandom(), $urandom()});
    v = 128'({d, ^d});
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = FRAME - 1; k >= 0; k--) begin
      tick(1'b1, v[k], 1'b0, 1'b0);
      n_checks++; if (if_m.sdout !== m_win[0]) begin n_errors++; $display("FAIL coll_sdout k=%0d: got %b expected %b", k, if_m.sdout, m_win[0]); end
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) rev[i] = d[N-1-i];
    n_checks++; if (if_l.cfg_out[0] !== d[N-1]) begin n_errors++; $display("FAIL lsb_first_bit: got %b expected %b", if_l.cfg_out[0], d[N-1]); end
    n_checks++; if (if_l.cfg_out !== rev) begin n_errors++; $display("FAIL lsb_cfg_out: got %h expected %h", if_l.cfg_out, rev); end
    n_checks++; if (if_m.cfg_out !== d) begin n_errors++; $display("FAIL msb_cfg_out: got %h expected %h", if_m.cfg_out, d); end
    n_checks++; if (if_m.err_len !== 1'b1) begin n_errors++; $display("FAIL coll_sticky: got %b expected 1", if_m.err_len); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_daisy();
    apply_reset(1'b0);
    for (int k = 1; k <= FRAME + 1; k++) begin
      tick(1'b1, (k == 1), 1'b0, 1'b0);
      n_checks++; if (if_m.sdout !== (k == FRAME)) begin n_errors++; $display("FAIL daisy_msb edge=%0d: got %b expected %b", k, if_m.sdout, (k == FRAME)); end
      n_checks++; if (if_l.sdout !== (k == FRAME)) begin n_errors++; $display("FAIL daisy_lsb edge=%0d: got %b expected %b", k, if_l.sdout, (k == FRAME)); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [127:0] v;
    apply_reset(1'b0);
    v = 128'({GOLD, 1'b1});
    shift_vec(v, FRAME, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    v = {$urandom(), $urandom(), $urandom(), 32'hFFFF_FFFF};
    shift_vec(v, 30, 1'b0);
    rst_n = 1'b0;
    #2;
    n_checks++; if (if_m.cfg_out !== RV || if_l.cfg_out !== RV) begin n_errors++; $display("FAIL midrst_cfg_out: got %h expected %h", if_m.cfg_out, RV); end
    n_checks++; if (if_m.sdout !== 1'b0 || if_m.bit_cnt !== '0) begin n_errors++; $display("FAIL midrst_sdout_cnt: got %b/%0d expected 0/0", if_m.sdout, if_m.bit_cnt); end
    n_checks++; if (if_m.cfg_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b expected 0", if_m.cfg_valid); end
    apply_reset(1'b0);
  endtask

  task automatic test_random();
    logic [3:0]   plan[$];
    logic [127:0] v;
    logic [N-1:0] d;
    bit           p;
    int           nb, sel;
    apply_reset(1'b0);
    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       nb = FRAME;
      else if (sel == 6) nb = N;
      else if (sel == 7) nb = FRAME + 1;
      else               nb = $urandom_range(1, 75);
      d = N'({$urandom(), $urandom()});
      p = ^d;
      if ($urandom_range(0, 3) == 0) p = ~p;
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      v[N:0] = {d, p};
      plan.delete();
      for (int k = nb - 1; k >= 0; k--) begin
        if ($urandom_range(0, 4) == 0) plan.push_back({1'b0, 1'($urandom_range(0, 1)), 2'b00});
        plan.push_back({1'b1, v[k], 2'b00});
      end
      repeat ($urandom_range(1, 3))
        plan.push_back({1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 7) == 0)});
      plan.push_back({3'b000, 1'($urandom_range(0, 5) == 0)});
      foreach (plan[i]) begin
        tick(plan[i][3], plan[i][2], plan[i][1], plan[i][0]);
        n_checks++; if (if_m.cfg_out !== m_cfg_m) begin n_errors++; $display("FAIL rnd_cfg_msb f=%0d: got %h expected %h", f, if_m.cfg_out, m_cfg_m); end
        n_checks++; if (if_l.cfg_out !== m_cfg_l) begin n_errors++; $display("FAIL rnd_cfg_lsb f=%0d: got %h expected %h", f, if_l.cfg_out, m_cfg_l); end
        n_checks++; if ({if_m.cfg_valid, if_m.err_len, if_m.err_par} !== {m_valid, m_errl, m_errp}) begin n_errors++; $display("FAIL rnd_flags f=%0d: got %b expected %b", f, {if_m.cfg_valid, if_m.err_len, if_m.err_par}, {m_valid, m_errl, m_errp}); end
        n_checks++; if ({if_l.cfg_valid, if_l.err_len, if_l.err_par} !== {m_valid, m_errl, m_errp}) begin n_errors++; $display("FAIL rnd_flags_lsb f=%0d: got %b expected %b", f, {if_l.cfg_valid, if_l.err_len, if_l.err_par}, {m_valid, m_errl, m_errp}); end
        n_checks++; if (if_m.bit_cnt !== CW'(m_cnt)) begin n_errors++; $display("FAIL rnd_bit_cnt f=%0d: got %0d expected %0d", f, if_m.bit_cnt, m_cnt); end
        n_checks++; if (if_m.sdout !== m_win[0] || if_l.sdout !== m_win[0]) begin n_errors++; $display("FAIL rnd_sdout f=%0d: got %b/%b expected %b", f, if_m.sdout, if_l.sdout, m_win[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_parity_error();
    test_length_errors();
    test_tied_high();
    test_collision();
    test_daisy();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
